pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 3-stage core (IF → ID → EX). Collects hazard and redirect events from ID and EX, plus the external interrupt request, and drives hold, flush and PC-load controls to the PC register, the IF/ID register and the ID/EX register. Owns the multi-cycle EX stall, the post-jump drain and the interrupt entry sequence.

Parameters:
FLUSH_CYCLES, 1, bubble cycles inserted after a jump; must be ≥1. The jump cycle counts as the first.
HOLD_TIMEOUT, 64, number of consecutive BUSY cycles after which hold_timeout_o pulses.
TRAP_VEC, 32'h0000_0004, PC loaded on interrupt entry.

Ports:
clk_i  input  1  core clock
rst_i  input  1  asynchronous, active-high reset
id_load_use_i  input  1  ID detected a load-use hazard
id_inst_addr_i  input  32  address of the instruction currently in ID
ex_busy_i  input  1  EX started or continues a multi-cycle operation
ex_done_i  input  1  EX multi-cycle operation completes this cycle
ex_jump_i  input  1  EX resolved a taken jump or branch
ex_jump_addr_i  input  32  jump target
irq_i  input  1  level interrupt request
irq_ack_o  output  1  interrupt taken this cycle
pc_hold_o  output  1  hold the PC register
if_id_hold_o  output  1  hold the IF/ID register
id_ex_hold_o  output  1  hold the ID/EX register
if_id_flush_o  output  1  load a NOP into IF/ID
id_ex_flush_o  output  1  load a NOP into ID/EX
pc_load_o  output  1  load the PC with pc_load_addr_o
pc_load_addr_o  output  32  new PC value
mepc_wen_o  output  1  write mepc
mepc_o  output  32  value for mepc
hold_timeout_o  output  1  one-cycle pulse on BUSY timeout

Behaviour:
- The FSM states are RUN, BUSY and FLUSH. State and counters are registered.
- All outputs are combinational from the state and the inputs, so control takes effect in the same cycle (zero latency).
- While rst_i=1: state=RUN, counters=0, every output forced to 0 regardless of inputs. Asserting rst_i mid-BUSY or mid-FLUSH aborts immediately.
- Outputs not listed for a case are 0. pc_load_addr_o=0 when pc_load_o=0. mepc_o=0 when mepc_wen_o=0.
- RUN evaluates events in priority order; only the first matching event acts:
  1. ex_jump_i: pc_load_o=1, pc_load_addr_o=ex_jump_addr_i, if_id_flush_o=id_ex_flush_o=1. If FLUSH_CYCLES>1: go to FLUSH with fcnt=FLUSH_CYCLES-1. Otherwise stay in RUN.
  2. ex_busy_i: pc_hold_o=if_id_hold_o=id_ex_hold_o=1, bcnt=1, go to BUSY.
  3. id_load_use_i: pc_hold_o=if_id_hold_o=1, id_ex_flush_o=1 (one bubble), stay in RUN.
  4. irq_i: irq_ack_o=1, pc_load_o=1, pc_load_addr_o=TRAP_VEC, if_id_flush_o=id_ex_flush_o=1, mepc_wen_o=1, mepc_o=id_inst_addr_i, stay in RUN.
- BUSY:
  - ex_done_i=0: all three holds=1. bcnt increments and saturates at HOLD_TIMEOUT. hold_timeout_o=1 only in the cycle bcnt transitions to HOLD_TIMEOUT. Holds persist after timeout.
  - ex_done_i=1: holds released. Apply RUN rules with ex_busy_i treated as 0. The next state is whatever those rules select (RUN or FLUSH).
  - ex_jump_i, id_load_use_i and irq_i are ignored while ex_done_i=0.
- FLUSH: if_id_flush_o=id_ex_flush_o=1, no hold, no PC load. fcnt decrements; return to RUN in the cycle fcnt becomes 0. ex_jump_i and ex_busy_i are ignored (EX holds a bubble). irq_i and id_load_use_i are deferred.
- irq_i is level-sensitive and not latched. Deferred requests are taken when RUN conditions allow and irq_i is still high.
- irq_ack_o is never asserted in the same cycle as any hold output.

Test Plan:
- Jump, FLUSH_CYCLES=3: ex_jump_i=1, ex_jump_addr_i=32'h0000_0100 in RUN → cycle 0: pc_load_o=1, addr=0x100, both flushes=1; cycles 1-2: both flushes=1, pc_load_o=0; cycle 3: all outputs 0, state=RUN.
- Load-use: id_load_use_i=1 for one cycle in RUN → pc_hold_o=if_id_hold_o=id_ex_flush_o=1, id_ex_hold_o=0; next cycle all outputs 0.
- Multi-cycle plus jump: ex_busy_i=1 for 5 cycles, then ex_done_i=1 with ex_jump_i=1, addr 0x200 → holds=1 for 5 cycles; done cycle: holds=0, pc_load_o=1, addr=0x200.
- Timeout, HOLD_TIMEOUT=4: ex_busy_i held, ex_done_i=0 for 10 cycles → hold_timeout_o=1 exactly once, in the 4th BUSY cycle; holds stay 1 throughout.
- Interrupt vs load-use: irq_i=1 and id_load_use_i=1 with id_inst_addr_i=0x80 → first cycle services load-use with irq_ack_o=0; next cycle (load-use cleared) irq_ack_o=1, pc_load_addr_o=0x4, mepc_wen_o=1, mepc_o=0x80.
- Reset mid-BUSY: assert rst_i asynchronously during BUSY → all outputs 0 immediately; after release, ex_busy_i=0 yields RUN with all outputs 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the IF/ID/EX core: turns hazard, redirect and interrupt
// events into same-cycle hold, flush and PC-load controls.
module pipe_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned HOLD_TIMEOUT = 64,
    parameter logic [31:0] TRAP_VEC     = 32'h0000_0004
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        id_load_use_i,
    input  logic [31:0] id_inst_addr_i,
    input  logic        ex_busy_i,
    input  logic        ex_done_i,
    input  logic        ex_jump_i,
    input  logic [31:0] ex_jump_addr_i,
    input  logic        irq_i,
    output logic        irq_ack_o,
    output logic        pc_hold_o,
    output logic        if_id_hold_o,
    output logic        id_ex_hold_o,
    output logic        if_id_flush_o,
    output logic        id_ex_flush_o,
    output logic        pc_load_o,
    output logic [31:0] pc_load_addr_o,
    output logic        mepc_wen_o,
    output logic [31:0] mepc_o,
    output logic        hold_timeout_o
);

    // state | meaning
    // RUN   | normal flow, events evaluated by priority
    // BUSY  | EX multi-cycle op in progress, pipeline held
    // FLUSH | post-jump drain, bubbles injected
    typedef enum logic [1:0] {S_RUN, S_BUSY, S_FLUSH} state_t;

    localparam int BW = $clog2(HOLD_TIMEOUT + 1);
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam logic [BW-1:0] HT_C    = BW'(HOLD_TIMEOUT);
    localparam logic [BW-1:0] BONE_C  = BW'(1);
    localparam logic [FW-1:0] FC_M1_C = FW'(FLUSH_CYCLES - 1);
    localparam logic [FW-1:0] FONE_C  = FW'(1);

    state_t        state_q, state_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          run_eval, busy_ok;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_RUN;
            bcnt_q  <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        bcnt_d         = bcnt_q;
        fcnt_d         = fcnt_q;
        run_eval       = 1'b0;
        busy_ok        = 1'b0;
        irq_ack_o      = 1'b0;
        pc_hold_o      = 1'b0;
        if_id_hold_o   = 1'b0;
        id_ex_hold_o   = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        pc_load_o      = 1'b0;
        pc_load_addr_o = '0;
        mepc_wen_o     = 1'b0;
        mepc_o         = '0;
        hold_timeout_o = 1'b0;

        case (state_q)
            S_RUN: begin
                run_eval = 1'b1;
                busy_ok  = 1'b1;
            end
            S_BUSY: begin
                if (!ex_done_i) begin
                    pc_hold_o    = 1'b1;
                    if_id_hold_o = 1'b1;
                    id_ex_hold_o = 1'b1;
                    if (bcnt_q != HT_C) begin
                        bcnt_d         = bcnt_q + BONE_C;
                        hold_timeout_o = ((bcnt_q + BONE_C) == HT_C);
                    end
                end else begin
                    // Completion cycle behaves as RUN with EX no longer busy.
                    run_eval = 1'b1;
                    state_d  = S_RUN;
                    bcnt_d   = '0;
                end
            end
            S_FLUSH: begin
                if_id_flush_o = 1'b1;
                id_ex_flush_o = 1'b1;
                fcnt_d        = fcnt_q - FONE_C;
                if (fcnt_q == FONE_C) state_d = S_RUN;
            end
            default: state_d = S_RUN;
        endcase

        if (run_eval) begin
            if (ex_jump_i) begin
                pc_load_o      = 1'b1;
                pc_load_addr_o = ex_jump_addr_i;
                if_id_flush_o  = 1'b1;
                id_ex_flush_o  = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    state_d = S_FLUSH;
                    fcnt_d  = FC_M1_C;
                end
            end else if (busy_ok && ex_busy_i) begin
                pc_hold_o      = 1'b1;
                if_id_hold_o   = 1'b1;
                id_ex_hold_o   = 1'b1;
                bcnt_d         = BONE_C;
                hold_timeout_o = (HT_C == BONE_C);
                state_d        = S_BUSY;
            end else if (id_load_use_i) begin
                pc_hold_o     = 1'b1;
                if_id_hold_o  = 1'b1;
                id_ex_flush_o = 1'b1;
            end else if (irq_i) begin
                irq_ack_o      = 1'b1;
                pc_load_o      = 1'b1;
                pc_load_addr_o = TRAP_VEC;
                if_id_flush_o  = 1'b1;
                id_ex_flush_o  = 1'b1;
                mepc_wen_o     = 1'b1;
                mepc_o         = id_inst_addr_i;
            end
        end

        if (rst_i) begin
            irq_ack_o      = 1'b0;
            pc_hold_o      = 1'b0;
            if_id_hold_o   = 1'b0;
            id_ex_hold_o   = 1'b0;
            if_id_flush_o  = 1'b0;
            id_ex_flush_o  = 1'b0;
            pc_load_o      = 1'b0;
            pc_load_addr_o = '0;
            mepc_wen_o     = 1'b0;
            mepc_o         = '0;
            hold_timeout_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized bench for pipe_ctrl against a cycle-level behavioural model of the
// sequencing rules, plus the directed scenarios (jump drain, busy+jump, timeout, irq).
module tb_pipe_ctrl;
    localparam int unsigned FC = 3;
    localparam int unsigned HT = 4;
    localparam logic [31:0] TV = 32'h0000_0004;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lu = 1'b0, busy = 1'b0, done = 1'b0, jmp = 1'b0, irq = 1'b0;
    logic [31:0] iaddr = '0, jaddr = '0;
    logic        irq_ack, pc_hold, if_id_hold, id_ex_hold, if_id_flush, id_ex_flush;
    logic        pc_load, mepc_wen, hold_to;
    logic [31:0] pc_addr, mepc;

    int total = 0;
    int bad   = 0;
    int to_cnt = 0;

    // Model: cycles of drain still owed, and consecutive busy cycles so far (0 = not busy).
    int m_flush = 0;
    int m_busy  = 0;

    pipe_ctrl #(.FLUSH_CYCLES(FC), .HOLD_TIMEOUT(HT), .TRAP_VEC(TV)) dut (
        .clk_i(clk), .rst_i(rst), .id_load_use_i(lu), .id_inst_addr_i(iaddr),
        .ex_busy_i(busy), .ex_done_i(done), .ex_jump_i(jmp), .ex_jump_addr_i(jaddr),
        .irq_i(irq), .irq_ack_o(irq_ack), .pc_hold_o(pc_hold), .if_id_hold_o(if_id_hold),
        .id_ex_hold_o(id_ex_hold), .if_id_flush_o(if_id_flush), .id_ex_flush_o(id_ex_flush),
        .pc_load_o(pc_load), .pc_load_addr_o(pc_addr), .mepc_wen_o(mepc_wen), .mepc_o(mepc),
        .hold_timeout_o(hold_to)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [8:0] ctl_obs();
        return {irq_ack, pc_hold, if_id_hold, id_ex_hold, if_id_flush, id_ex_flush,
                pc_load, mepc_wen, hold_to};
    endfunction

    // One clock cycle: drive at negedge, optionally pulse reset, check, advance model.
    task automatic cyc(input logic j, input logic [31:0] ja, input logic b, input logic d,
                       input logic l, input logic q, input logic [31:0] ia, input bit rst_mid);
        logic [8:0]  e_ctl;
        logic [31:0] e_addr, e_mepc;
        int nf, nb;
        bit in_busy;
        @(negedge clk);
        rst = 1'b0;
        jmp = j; jaddr = ja; busy = b; done = d; lu = l; irq = q; iaddr = ia;
        #1;
        if (rst_mid) begin
            rst = 1'b1;
            #1;
        end
        e_ctl = '0; e_addr = '0; e_mepc = '0;
        nf = m_flush; nb = m_busy;
        if (rst_mid) begin
            nf = 0; nb = 0;
        end else if (m_flush > 0) begin
            e_ctl[4] = 1'b1; e_ctl[3] = 1'b1;
            nf = m_flush - 1;
        end else if (m_busy > 0 && !d) begin
            e_ctl[7:5] = 3'b111;
            if (m_busy < int'(HT)) begin
                nb = m_busy + 1;
                e_ctl[0] = (nb == int'(HT));
            end
        end else begin
            in_busy = (m_busy > 0);
            nb = 0;
            if (j) begin
                e_ctl[4] = 1'b1; e_ctl[3] = 1'b1; e_ctl[2] = 1'b1; e_addr = ja;
                nf = int'(FC) - 1;
            end else if (!in_busy && b) begin
                e_ctl[7:5] = 3'b111;
                nb = 1;
                e_ctl[0] = (HT == 1);
            end else if (l) begin
                e_ctl[7] = 1'b1; e_ctl[6] = 1'b1; e_ctl[3] = 1'b1;
            end else if (q) begin
                e_ctl[8] = 1'b1; e_ctl[4] = 1'b1; e_ctl[3] = 1'b1; e_ctl[2] = 1'b1;
                e_ctl[1] = 1'b1; e_addr = TV; e_mepc = ia;
            end
        end
        chk("ctl", 64'(ctl_obs()), 64'(e_ctl));
        chk("pc_addr", 64'(pc_addr), 64'(e_addr));
        chk("mepc", 64'(mepc), 64'(e_mepc));
        chk("ack_vs_hold", 64'(irq_ack & (pc_hold | if_id_hold | id_ex_hold)), 64'(0));
        if (hold_to) to_cnt++;
        @(posedge clk);
        m_flush = nf;
        m_busy  = nb;
    endtask

    initial begin
        // Outputs forced low while reset is held, whatever the inputs.
        jmp = 1'b1; jaddr = 32'hdead_beef; busy = 1'b1; lu = 1'b1; irq = 1'b1; iaddr = 32'h44;
        #3;
        chk("rst_ctl", 64'(ctl_obs()), 64'(0));
        chk("rst_addr", 64'(pc_addr), 64'(0));
        chk("rst_mepc", 64'(mepc), 64'(0));
        repeat (2) @(posedge clk);

        // Jump with three-cycle drain, then idle.
        cyc(1, 32'h100, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 32'h300, 1, 0, 1, 1, 32'h10, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        // Load-use for one cycle.
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        // Five busy cycles then done together with a jump.
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, i[0], i[1], 0, 0);
        cyc(1, 32'h200, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
        // Timeout pulses exactly once over ten held cycles.
        to_cnt = 0;
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0, 0, 0, 0, 0);
        chk("to_once", 64'(to_cnt), 64'(1));
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        // Interrupt deferred behind load-use.
        cyc(0, 0, 0, 0, 1, 1, 32'h80, 0);
        cyc(0, 0, 0, 0, 0, 1, 32'h80, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        // Reset asserted mid-busy, then idle after release.
        cyc(0, 0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(7) == 0), $urandom, ($urandom_range(3) == 0),
                ($urandom_range(3) == 0), ($urandom_range(3) == 0), ($urandom_range(2) == 0),
                $urandom, ($urandom_range(199) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
